// File: rtl/sync_short_gen.sv
// Short-preamble detector: delay-and-correlate metric against a programmable
// fraction of the average power, plateau/sign-diversity qualification,
// hold-off after detection and phase-offset capture from an external CORDIC.
module sync_short_gen #(
    parameter int         DATA_WIDTH        = 16,
    parameter int         DELAY_SHIFT       = 4,
    parameter int         WINDOW_SHIFT      = 4,
    parameter int         FREQ_WINDOW_SHIFT = 6,
    parameter logic [7:0] SR_BASE           = 8'd2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    input  logic [2*DATA_WIDTH-1:0] sample_in,
    input  logic                    sample_in_strobe,
    output logic [31:0]             phase_in_i,
    output logic [31:0]             phase_in_q,
    output logic                    phase_in_stb,
    input  logic [31:0]             phase_out,
    input  logic                    phase_out_stb,
    output logic                    short_preamble_detected,
    output logic [31:0]             phase_offset,
    output logic [15:0]             plateau_len,
    output logic [1:0]              state
);

    localparam int DW   = DATA_WIDTH;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int PW1  = PW + 1;
    localparam int DLEN = 1 << DELAY_SHIFT;
    localparam int WLEN = 1 << WINDOW_SHIFT;
    localparam int FLEN = 1 << FREQ_WINDOW_SHIFT;

    typedef enum logic [1:0] {IDLE = 2'd0, PLATEAU = 2'd1, HOLDOFF = 2'd2} state_t;

    logic [15:0] minPlateau_q;
    logic [3:0]  thresNum_q;
    logic [7:0]  maxGap_q;
    logic [15:0] holdoff_q;
    logic [15:0] unusedSetData;
    assign unusedSetData = set_data[31:16];

    // Settings bus: writes land one cycle after the strobe and are not frozen by enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            minPlateau_q <= 16'd100;
            thresNum_q   <= 4'd6;
            maxGap_q     <= 8'd0;
            holdoff_q    <= 16'd320;
        end else if (set_stb) begin
            if (set_addr == SR_BASE)         minPlateau_q <= set_data[15:0];
            if (set_addr == SR_BASE + 8'd1)  thresNum_q   <= set_data[3:0];
            if (set_addr == SR_BASE + 8'd2)  maxGap_q     <= set_data[7:0];
            if (set_addr == SR_BASE + 8'd3)  holdoff_q    <= set_data[15:0];
        end
    end

    logic [PW-1:0]          dlyLine_q [DLEN];
    logic signed [DW-1:0]   curI_q, curQ_q, dlyI_q, dlyNegQ_q;
    logic                   stb1_q;
    logic signed [DW-1:0]   dlyQ, negQ;

    // Conjugate of the lagged sample; the most-negative Q saturates so products fit in PW bits.
    always_comb begin
        dlyQ = dlyLine_q[DLEN-1][DW-1:0];
        negQ = -dlyQ;
        if (dlyQ == {1'b1, {(DW-1){1'b0}}}) negQ = {1'b0, {(DW-1){1'b1}}};
    end

    // Lag line of D samples plus the registered current/conjugated-lagged pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DLEN; i++) dlyLine_q[i] <= '0;
            curI_q <= '0; curQ_q <= '0; dlyI_q <= '0; dlyNegQ_q <= '0;
            stb1_q <= 1'b0;
        end else if (enable) begin
            stb1_q <= sample_in_strobe;
            if (sample_in_strobe) begin
                dlyLine_q[0] <= sample_in;
                for (int i = 1; i < DLEN; i++) dlyLine_q[i] <= dlyLine_q[i-1];
                curI_q    <= sample_in[PW-1:DW];
                curQ_q    <= sample_in[DW-1:0];
                dlyI_q    <= dlyLine_q[DLEN-1][PW-1:DW];
                dlyNegQ_q <= negQ;
            end
        end
    end

    logic signed [PW1-1:0] reFull, imFull, magFull;
    logic signed [PW-1:0]  prodRe_q, prodIm_q;
    logic [PW-1:0]         magSq_q;
    logic                  stb2_q;

    // Complex product with the conjugated lagged sample and the instantaneous power.
    always_comb begin
        reFull  = PW1'(curI_q) * PW1'(dlyI_q)    - PW1'(curQ_q) * PW1'(dlyNegQ_q);
        imFull  = PW1'(curI_q) * PW1'(dlyNegQ_q) + PW1'(curQ_q) * PW1'(dlyI_q);
        magFull = PW1'(curI_q) * PW1'(curI_q)    + PW1'(curQ_q) * PW1'(curQ_q);
    end

    // Register products once per sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            prodRe_q <= '0; prodIm_q <= '0; magSq_q <= '0; stb2_q <= 1'b0;
        end else if (enable) begin
            stb2_q <= stb1_q;
            if (stb1_q) begin
                prodRe_q <= reFull[PW-1:0];
                prodIm_q <= imFull[PW-1:0];
                magSq_q  <= magFull[PW-1:0];
            end
        end
    end

    logic signed [31:0] reWin_q [WLEN];
    logic signed [31:0] imWin_q [WLEN];
    logic [31:0]        magWin_q [WLEN];
    logic signed [31:0] reFWin_q [FLEN];
    logic signed [31:0] imFWin_q [FLEN];
    logic signed [31:0] reSum_q, imSum_q, reFSum_q, imFSum_q;
    logic [31:0]        magSum_q;
    logic               stb3_q;
    logic signed [31:0] reSh, imSh, reFSh, imFSh;
    logic [31:0]        magSh;

    // Each term is pre-scaled by the window length so the running sum is the average in 32 bits.
    always_comb begin
        reSh  = 32'(prodRe_q) >>> WINDOW_SHIFT;
        imSh  = 32'(prodIm_q) >>> WINDOW_SHIFT;
        magSh = 32'(magSq_q) >> WINDOW_SHIFT;
        reFSh = 32'(prodRe_q) >>> FREQ_WINDOW_SHIFT;
        imFSh = 32'(prodIm_q) >>> FREQ_WINDOW_SHIFT;
    end

    // Moving averages: add the newest term, drop the one leaving the window.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WLEN; i++) begin
                reWin_q[i] <= '0; imWin_q[i] <= '0; magWin_q[i] <= '0;
            end
            for (int i = 0; i < FLEN; i++) begin
                reFWin_q[i] <= '0; imFWin_q[i] <= '0;
            end
            reSum_q <= '0; imSum_q <= '0; magSum_q <= '0; reFSum_q <= '0; imFSum_q <= '0;
            stb3_q <= 1'b0;
        end else if (enable) begin
            stb3_q <= stb2_q;
            if (stb2_q) begin
                reWin_q[0] <= reSh; imWin_q[0] <= imSh; magWin_q[0] <= magSh;
                reFWin_q[0] <= reFSh; imFWin_q[0] <= imFSh;
                for (int i = 1; i < WLEN; i++) begin
                    reWin_q[i] <= reWin_q[i-1]; imWin_q[i] <= imWin_q[i-1]; magWin_q[i] <= magWin_q[i-1];
                end
                for (int i = 1; i < FLEN; i++) begin
                    reFWin_q[i] <= reFWin_q[i-1]; imFWin_q[i] <= imFWin_q[i-1];
                end
                reSum_q  <= reSum_q  + reSh  - reWin_q[WLEN-1];
                imSum_q  <= imSum_q  + imSh  - imWin_q[WLEN-1];
                magSum_q <= magSum_q + magSh - magWin_q[WLEN-1];
                reFSum_q <= reFSum_q + reFSh - reFWin_q[FLEN-1];
                imFSum_q <= imFSum_q + imFSh - imFWin_q[FLEN-1];
            end
        end
    end

    assign phase_in_i   = reFSum_q;
    assign phase_in_q   = imFSum_q;
    assign phase_in_stb = stb3_q;

    logic [31:0] absRe, absIm, mx, mn, thresNew;
    logic [32:0] metricNew;
    logic [35:0] thresProd, thresShift;
    logic [32:0] metric_q;
    logic [31:0] thres_q;
    logic        metricStb_q;

    // Magnitude approximated as max + min/4; threshold is a num/8 fraction of average power.
    always_comb begin
        absRe      = reSum_q[31] ? $unsigned(-reSum_q) : $unsigned(reSum_q);
        absIm      = imSum_q[31] ? $unsigned(-imSum_q) : $unsigned(imSum_q);
        mx         = (absRe > absIm) ? absRe : absIm;
        mn         = (absRe > absIm) ? absIm : absRe;
        metricNew  = {1'b0, mx} + {3'b000, mn[31:2]};
        thresProd  = 36'(magSum_q) * 36'(thresNum_q);
        thresShift = thresProd >> 3;
        thresNew   = (|thresShift[35:32]) ? 32'hFFFF_FFFF : thresShift[31:0];
    end

    // Register metric and threshold together so the FSM sees a consistent pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            metric_q <= '0; thres_q <= '0; metricStb_q <= 1'b0;
        end else if (enable) begin
            metricStb_q <= stb3_q;
            if (stb3_q) begin
                metric_q <= metricNew;
                thres_q  <= thresNew;
            end
        end
    end

    logic [31:0] phaseOut_q;

    // Keep the most recent CORDIC angle for use at detection time.
    always_ff @(posedge clock) begin
        if (reset)                         phaseOut_q <= '0;
        else if (enable && phase_out_stb)  phaseOut_q <= phase_out;
    end

    state_t             state_q, state_d;
    logic [15:0]        len_q, len_d, pos_q, pos_d, neg_q, neg_d, hold_q, hold_d;
    logic [8:0]         gap_q, gap_d, gapInc;
    logic               det_q, det_d, above, signNeg;
    logic [15:0]        quarter;
    logic signed [31:0] phaseSrc, offsetNew, offset_q, offset_d;

    // Detection FSM: all decisions are taken only on metric strobes.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        pos_d    = pos_q;
        neg_d    = neg_q;
        gap_d    = gap_q;
        hold_d   = hold_q;
        det_d    = 1'b0;
        offset_d = offset_q;
        above     = metric_q > {1'b0, thres_q};
        signNeg   = sample_in[PW-1];
        quarter   = minPlateau_q >> 2;
        gapInc    = gap_q + 9'd1;
        phaseSrc  = phase_out_stb ? phase_out : phaseOut_q;
        offsetNew = (-phaseSrc) >>> DELAY_SHIFT;
        if (metricStb_q) begin
            case (state_q)
                IDLE: begin
                    if (above) begin
                        state_d = PLATEAU;
                        len_d   = 16'd1;
                        gap_d   = '0;
                        pos_d   = signNeg ? 16'd0 : 16'd1;
                        neg_d   = signNeg ? 16'd1 : 16'd0;
                    end
                end
                PLATEAU: begin
                    if (above && (len_q > minPlateau_q)) begin
                        if ((pos_q > quarter) && (neg_q > quarter)) begin
                            det_d    = 1'b1;
                            offset_d = offsetNew;
                            state_d  = HOLDOFF;
                            hold_d   = holdoff_q;
                        end else begin
                            state_d = IDLE;
                        end
                        len_d = '0; pos_d = '0; neg_d = '0; gap_d = '0;
                    end else if (above) begin
                        len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                        gap_d = '0;
                        if (signNeg) neg_d = (neg_q == 16'hFFFF) ? neg_q : neg_q + 16'd1;
                        else         pos_d = (pos_q == 16'hFFFF) ? pos_q : pos_q + 16'd1;
                    end else if (gapInc > {1'b0, maxGap_q}) begin
                        state_d = IDLE;
                        len_d = '0; pos_d = '0; neg_d = '0; gap_d = '0;
                    end else begin
                        gap_d = gapInc;
                    end
                end
                HOLDOFF: begin
                    if (hold_q == 16'd0) state_d = IDLE;
                    else                 hold_d  = hold_q - 16'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register; everything holds while enable is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE; len_q <= '0; pos_q <= '0; neg_q <= '0; gap_q <= '0;
            hold_q <= '0; det_q <= 1'b0; offset_q <= '0;
        end else if (enable) begin
            state_q <= state_d; len_q <= len_d; pos_q <= pos_d; neg_q <= neg_d; gap_q <= gap_d;
            hold_q <= hold_d; det_q <= det_d; offset_q <= offset_d;
        end
    end

    assign short_preamble_detected = det_q & enable;
    assign phase_offset            = offset_q;
    assign plateau_len             = len_q;
    assign state                   = state_q;

endmodule
